// File: rtl/rand_matrix_fill.sv
// Fills a rows x cols matrix with values from an external range-mapped LFSR.
// Each element is written row-major through a valid/ready port.
module rand_matrix_fill #(
  parameter int MAX_DIM   = 5,
  parameter int PRIME_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] cfg_rows,
  input  logic [2:0] cfg_cols,
  input  logic [7:0] cfg_lo,
  input  logic [7:0] cfg_hi,
  output logic       rng_en,
  output logic [7:0] rng_min,
  output logic [7:0] rng_max,
  input  logic [7:0] rng_val,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // state  | meaning
  // IDLE   | waiting for start; err pulses here after a rejected request
  // SETTLE | one quiet cycle so the generator captures the new bounds
  // PRIME  | PRIME_CYC enabled cycles flushing the generator pipeline
  // GEN    | issuing element writes, generator frozen while stalled
  // FIN    | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, SETTLE, PRIME, GEN, FIN} state_t;

  state_t     state, state_nxt;
  logic [2:0] rows_q, cols_q, row_q, col_q;
  logic [7:0] lo_q, hi_q;
  logic [7:0] prime_cnt;
  logic       err_q;
  logic       cfg_ok, hs, last_elem;

  assign cfg_ok = (cfg_rows != 3'd0) && (cfg_cols != 3'd0) &&
                  (32'(cfg_rows) <= MAX_DIM) && (32'(cfg_cols) <= MAX_DIM) &&
                  ($signed(cfg_lo) <= $signed(cfg_hi));
  assign hs        = wr_valid && wr_ready;
  assign last_elem = (row_q == 3'(rows_q - 3'd1)) && (col_q == 3'(cols_q - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      prime_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rows_q <= cfg_rows;
            cols_q <= cfg_cols;
            lo_q   <= cfg_lo;
            hi_q   <= cfg_hi;
            row_q  <= '0;
            col_q  <= '0;
            err_q  <= !cfg_ok;
          end
        end
        SETTLE: prime_cnt <= 8'(PRIME_CYC - 1);
        PRIME: if (prime_cnt != '0) prime_cnt <= prime_cnt - 8'd1;
        GEN: begin
          if (hs) begin
            if (col_q == 3'(cols_q - 3'd1)) begin
              col_q <= '0;
              row_q <= row_q + 3'd1;
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rng_en    = 1'b0;
    wr_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start && cfg_ok) state_nxt = SETTLE;
      SETTLE: state_nxt = PRIME;
      PRIME: begin
        rng_en = 1'b1;
        if (prime_cnt == '0) state_nxt = GEN;
      end
      GEN: begin
        wr_valid = 1'b1;
        rng_en   = wr_ready;
        if (hs && last_elem) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Indices and data are only meaningful during GEN; elsewhere they read 0.
  assign wr_row  = (state == GEN) ? row_q : 3'd0;
  assign wr_col  = (state == GEN) ? col_q : 3'd0;
  assign wr_data = (state == GEN) ? rng_val : 8'd0;
  assign rng_min = lo_q;
  assign rng_max = hi_q;
  assign busy    = (state != IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_rand_matrix_fill.sv
// Scoreboard bench for rand_matrix_fill: a behavioural range-mapped generator
// feeds rng_val, a monitor checks every write, done and stall against a model.
module tb_rand_matrix_fill;
  localparam int MAX_DIM   = 5;
  localparam int PRIME_CYC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cfg_rows = '0, cfg_cols = '0;
  logic [7:0] cfg_lo = '0, cfg_hi = '0;
  logic       rng_en;
  logic [7:0] rng_min, rng_max;
  logic [7:0] rng_val;
  logic       wr_valid, wr_ready;
  logic [2:0] wr_row, wr_col;
  logic [7:0] wr_data;
  logic       busy, done, err;

  rand_matrix_fill #(.MAX_DIM(MAX_DIM), .PRIME_CYC(PRIME_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .rng_en(rng_en), .rng_min(rng_min), .rng_max(rng_max),
    .rng_val(rng_val), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int row; int col; int lo; int hi;} exp_t;
  exp_t sbq[$];
  int   gen_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, start_cyc = 0, last_hs = 0;
  int   fill_k = 0, stall_cnt = 0;
  int   ready_mode = 0, stall_left = 0;
  bit   timing_on = 0;
  bit   prev_stall = 0;
  logic [7:0] held_data;
  logic [2:0] held_row, held_col;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural generator: registered value uniformly mapped into [rng_min, rng_max].
  int g_lo, g_hi, g_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rng_val <= 8'd0;
    else if (rng_en) begin
      g_lo = int'($signed(rng_min));
      g_hi = int'($signed(rng_max));
      if (g_hi < g_lo) g_v = g_lo;
      else g_v = g_lo + int'($urandom % 32'(g_hi - g_lo + 1));
      rng_val <= 8'(g_v);
      gen_q.push_back(g_v);
    end
  end

  // Storage-side ready: 0 always ready, 1 random, 2 stall stall_left cycles at col 1.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      1: wr_ready = ($urandom % 3) != 0;
      2: begin
        if (wr_valid && wr_col == 3'd1 && stall_left > 0) begin
          wr_ready = 1'b0;
          stall_left--;
        end else wr_ready = 1'b1;
      end
      default: wr_ready = 1'b1;
    endcase
  end

  exp_t e;
  int   d;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && wr_valid) begin
        check("stall_data_hold", int'(wr_data), int'(held_data));
        check("stall_row_hold", int'(wr_row), int'(held_row));
        check("stall_col_hold", int'(wr_col), int'(held_col));
      end
      prev_stall = 0;
      if (wr_valid && !wr_ready) begin
        check("stall_rng_en", int'(rng_en), 0);
        held_data = wr_data; held_row = wr_row; held_col = wr_col;
        prev_stall = 1;
        stall_cnt++;
      end
      if (wr_valid && wr_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: row %0d col %0d with no fill pending", wr_row, wr_col);
        end else begin
          e = sbq.pop_front();
          d = int'($signed(wr_data));
          check("wr_row", int'(wr_row), e.row);
          check("wr_col", int'(wr_col), e.col);
          check("data_in_range", int'(d >= e.lo && d <= e.hi), 1);
          if (PRIME_CYC - 1 + fill_k < gen_q.size())
            check("data_vs_generator", d, gen_q[PRIME_CYC - 1 + fill_k]);
          else check("generator_history", gen_q.size(), PRIME_CYC + fill_k);
          check("busy_in_gen", int'(busy), 1);
          if (timing_on && fill_k == 0) check("first_hs_latency", cyc - start_cyc, 2 + PRIME_CYC);
          fill_k++;
          last_hs = cyc;
        end
      end
      if (done) begin
        check("done_after_last_write", cyc - last_hs, 1);
        check("done_sb_empty", sbq.size(), 0);
      end
    end
  end

  task automatic do_start(input int rows, input int cols, input int lo, input int hi, input bit ok);
    @(negedge clk);
    cfg_rows = 3'(rows); cfg_cols = 3'(cols); cfg_lo = 8'(lo); cfg_hi = 8'(hi);
    start = 1'b1;
    start_cyc = cyc;
    if (ok) begin
      fill_k = 0;
      gen_q.delete();
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) sbq.push_back('{r, c, lo, hi});
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 400) check({name, "_timeout"}, 0, 1);
    @(negedge clk);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_done_width"}, int'(done), 0);
  endtask

  task automatic bad_start(input string name, input int rows, input int cols, input int lo, input int hi);
    do_start(rows, cols, lo, hi, 0);
    @(negedge clk);
    check({name, "_err"}, int'(err), 1);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_wr_valid"}, int'(wr_valid), 0);
    @(negedge clk);
    check({name, "_err_width"}, int'(err), 0);
    check({name, "_still_idle"}, int'(busy), 0);
  endtask

  task automatic check_zero(input string name);
    check(name, int'({rng_en, wr_valid, wr_row, wr_col, busy, done, err, rng_min, rng_max}), 0);
  endtask

  int rr, cc, lo, hi, t, n;
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst_n = 1'b1;

    timing_on = 1;
    do_start(2, 3, 0, 9, 1);
    wait_done("fill_2x3");
    check("fill_2x3_count", fill_k, 6);

    bad_start("rows0", 0, 3, 0, 9);
    bad_start("rows6", 6, 3, 0, 9);
    bad_start("cols7", 2, 7, 0, 9);
    bad_start("lo_gt_hi", 2, 2, 5, -3);

    ready_mode = 2; stall_left = 4; stall_cnt = 0;
    do_start(1, 2, -20, 20, 1);
    wait_done("stall_1x2");
    check("stall_count", stall_cnt, 4);
    check("stall_writes", fill_k, 2);
    ready_mode = 0;

    do_start(5, 5, -7, -7, 1);
    repeat (3) @(negedge clk);
    // A start while busy must be ignored: different config would corrupt bounds.
    start = 1'b1; cfg_rows = 3'd1; cfg_cols = 3'd1; cfg_lo = 8'd100; cfg_hi = 8'd120;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored_min", int'(rng_min), 8'hF9);
    wait_done("fill_5x5_const");
    check("fill_5x5_count", fill_k, 25);

    timing_on = 0;
    ready_mode = 1;
    for (int it = 0; it < 8; it++) begin
      rr = $urandom_range(1, MAX_DIM); cc = $urandom_range(1, MAX_DIM);
      lo = int'($signed(8'($urandom))); hi = int'($signed(8'($urandom)));
      if (lo > hi) begin t = lo; lo = hi; hi = t; end
      do_start(rr, cc, lo, hi, 1);
      wait_done("rand_fill");
      check("rand_fill_count", fill_k, rr * cc);
    end
    ready_mode = 0;

    do_start(3, 3, -50, 50, 1);
    n = 0;
    while (fill_k < 3 && n < 100) begin @(negedge clk); n++; end
    check("reset_mid_reached", fill_k, 3);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_outputs");
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    timing_on = 1;
    do_start(1, 1, 3, 3, 1);
    wait_done("fill_1x1");
    check("fill_1x1_count", fill_k, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
